// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the txuart.
// master: the arbiter side. slave: requesters plus the txuart busy source.
interface uart_tx_arbiter_if #(
   parameter int unsigned NREQ = 4
) ();
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   req_last;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   grant;
   logic              tx_wr;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic              timeout_err;

   modport master (
      input  req, req_last, req_data, tx_busy,
      output ack, grant, tx_wr, tx_data, timeout_err
   );

   modport slave (
      output req, req_last, req_data, tx_busy,
      input  ack, grant, tx_wr, tx_data, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-message arbiter sharing one txuart among NREQ byte streams.
// A granted requester keeps the transmitter until its last byte is accepted or
// it leaves req low for TIMEOUT cycles while the arbiter is ready to issue.
module uart_tx_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned GAP_CYCLES = 1,
   parameter int unsigned TIMEOUT    = 1024
) (
   input logic               clk,
   input logic               rst_n,
   uart_tx_arbiter_if.master bus
);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP,
      DRAIN
   } state_e;

   state_e            state_q;
   logic [PW-1:0]     ptr_q;
   logic [TW-1:0]     tmo_q;
   logic [GW-1:0]     gap_q;
   logic              last_q;
   logic [NREQ-1:0]   ack_q;
   logic [NREQ-1:0]   grant_q;
   logic              tx_wr_q;
   logic [7:0]        tx_data_q;
   logic              tmo_err_q;

   logic [PW-1:0]     sel_d;
   logic              any_d;
   logic              req_g;
   logic              last_g;
   logic [7:0]        data_g;

   logic [PW-1:0]     sel_hi;
   logic [PW-1:0]     sel_lo;
   logic              found_hi;
   logic              found_lo;

   // Rotating priority: lowest set req above the pointer, else lowest at/below it.
   always_comb begin
      sel_hi   = '0;
      sel_lo   = '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (bus.req[i]) begin
            if (PW'(i) > ptr_q) begin
               if (!found_hi) begin
                  found_hi = 1'b1;
                  sel_hi   = PW'(i);
               end
            end else if (!found_lo) begin
               found_lo = 1'b1;
               sel_lo   = PW'(i);
            end
         end
      end
      any_d = found_hi | found_lo;
      sel_d = found_hi ? sel_hi : sel_lo;
   end

   // Route the current owner's req/last/data; all zero while nobody is granted.
   always_comb begin
      req_g  = 1'b0;
      last_g = 1'b0;
      data_g = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_q[i]) begin
            req_g  = req_g  | bus.req[i];
            last_g = last_g | bus.req_last[i];
            data_g = data_g | bus.req_data[8*i +: 8];
         end
      end
   end

   // Arbitration / issue / pacing FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= PTR_RST;
         tmo_q     <= '0;
         gap_q     <= '0;
         last_q    <= 1'b0;
         ack_q     <= '0;
         grant_q   <= '0;
         tx_wr_q   <= 1'b0;
         tx_data_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         ack_q     <= '0;
         tx_wr_q   <= 1'b0;
         tmo_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_d && !bus.tx_busy) begin
                  grant_q <= NREQ'(1) << sel_d;
                  ptr_q   <= sel_d;
                  tmo_q   <= '0;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               // A present byte beats an expiring timer in the same cycle.
               if (req_g && !bus.tx_busy) begin
                  tx_data_q <= data_g;
                  tx_wr_q   <= 1'b1;
                  ack_q     <= grant_q;
                  last_q    <= last_g;
                  tmo_q     <= '0;
                  gap_q     <= '0;
                  state_q   <= GAP;
               end else if (!req_g) begin
                  if (tmo_q == TMO_LAST) begin
                     grant_q   <= '0;
                     tmo_err_q <= 1'b1;
                     tmo_q     <= '0;
                     state_q   <= IDLE;
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end
            end
            GAP: begin
               // tx_busy is not trusted here: txuart needs a cycle to raise it.
               if (gap_q == GAP_LAST) begin
                  state_q <= DRAIN;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            DRAIN: begin
               if (!bus.tx_busy) begin
                  if (last_q) begin
                     grant_q <= '0;
                     state_q <= IDLE;
                  end else begin
                     state_q <= ISSUE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ack         = ack_q;
   assign bus.grant       = grant_q;
   assign bus.tx_wr       = tx_wr_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.timeout_err = tmo_err_q;

endmodule
